// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared defines and package for the writeback stage.
//
// Defines (each overridable on the command line):
//   `DWIDTH      data width (32)
//   `AWIDTH      register address width (5)
//   `WB_DEPTH    default in-order buffer depth (4)
//   `WB_ENTRY_W  width of one buffered entry, laid out as {addr[AWIDTH], data[DWIDTH]}
//
// Optional feature macro: WB_BYPASS_EN (used by wb_fifo) lets an incoming entry
// go straight to the output register when the buffer is empty.

`ifndef DWIDTH
`define DWIDTH 32
`endif

`ifndef AWIDTH
`define AWIDTH 5
`endif

`ifndef WB_DEPTH
`define WB_DEPTH 4
`endif

`ifndef WB_ENTRY_W
`define WB_ENTRY_W (`AWIDTH + `DWIDTH)
`endif

package writeback_stage_pkg;

    localparam int unsigned WbDepthDefault = `WB_DEPTH;
    localparam int unsigned DWidthDefault  = `DWIDTH;
    localparam int unsigned AWidthDefault  = `AWIDTH;
    localparam int unsigned EntryWDefault  = `WB_ENTRY_W;

    // Where the entry popped this cycle comes from.
    typedef enum logic [1:0] {
        PopNone,
        PopHead,
        PopLane
    } pop_src_e;

    // A lane retires into the buffer only if it writes a real register ($0 is dropped).
    function automatic logic lane_qualifies(input logic valid, input logic reg_write,
                                            input logic rd_nonzero);
        return valid & reg_write & rd_nonzero;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: bundle of the two execution-lane retire ports and the
// register-file write port of the writeback stage.
//
// Signals:
//   wb_i_ce                      stage enable (low = stall)
//   wb_i_valid0/1                lane result valid, lane 0 older
//   wb_i_reg_write0/1            lane writes a register
//   wb_i_memtoreg0/1             select load data over ALU result
//   wb_i_addr_rd0/1              destination register
//   wb_i_alu_result0/1           ALU result
//   wb_i_mem_data0/1             load data
//   wb_o_ready                   both lanes may be presented this cycle
//   wb_o_reg_write/addr_rd/data_rd  register-file write port
//   wb_o_pending                 buffer non-empty
//   wb_o_count                   buffered entries
//
// Modports: master = lane producer / register-file side, slave = writeback_stage.

interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int unsigned WB_DEPTH = WbDepthDefault,
    parameter int unsigned DWIDTH   = DWidthDefault,
    parameter int unsigned AWIDTH   = AWidthDefault,
    localparam int unsigned CntW    = $clog2(WB_DEPTH + 1)
);

    logic              wb_i_ce;
    logic              wb_i_valid0;
    logic              wb_i_valid1;
    logic              wb_i_reg_write0;
    logic              wb_i_reg_write1;
    logic              wb_i_memtoreg0;
    logic              wb_i_memtoreg1;
    logic [AWIDTH-1:0] wb_i_addr_rd0;
    logic [AWIDTH-1:0] wb_i_addr_rd1;
    logic [DWIDTH-1:0] wb_i_alu_result0;
    logic [DWIDTH-1:0] wb_i_alu_result1;
    logic [DWIDTH-1:0] wb_i_mem_data0;
    logic [DWIDTH-1:0] wb_i_mem_data1;

    logic              wb_o_ready;
    logic              wb_o_reg_write;
    logic [AWIDTH-1:0] wb_o_addr_rd;
    logic [DWIDTH-1:0] wb_o_data_rd;
    logic              wb_o_pending;
    logic [CntW-1:0]   wb_o_count;

    modport master (
        output wb_i_ce,
        output wb_i_valid0, wb_i_valid1,
        output wb_i_reg_write0, wb_i_reg_write1,
        output wb_i_memtoreg0, wb_i_memtoreg1,
        output wb_i_addr_rd0, wb_i_addr_rd1,
        output wb_i_alu_result0, wb_i_alu_result1,
        output wb_i_mem_data0, wb_i_mem_data1,
        input  wb_o_ready,
        input  wb_o_reg_write, wb_o_addr_rd, wb_o_data_rd,
        input  wb_o_pending, wb_o_count
    );

    modport slave (
        input  wb_i_ce,
        input  wb_i_valid0, wb_i_valid1,
        input  wb_i_reg_write0, wb_i_reg_write1,
        input  wb_i_memtoreg0, wb_i_memtoreg1,
        input  wb_i_addr_rd0, wb_i_addr_rd1,
        input  wb_i_alu_result0, wb_i_alu_result1,
        input  wb_i_mem_data0, wb_i_mem_data1,
        output wb_o_ready,
        output wb_o_reg_write, wb_o_addr_rd, wb_o_data_rd,
        output wb_o_pending, wb_o_count
    );

endinterface

// File: rtl/writeback_stage_fifo.sv
// wb_fifo: dual-push, single-pop circular buffer with occupancy count.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   push_cnt                number of entries pushed this cycle (0..2)
//   push_entry0/1           entries in program order; entry1 valid only when push_cnt == 2
//   pop_req                 pop one entry this cycle if one is available
//   pop_valid, pop_entry    popped entry
//   count                   registered occupancy
//   count_next              occupancy after this cycle's push/pop
//
// With WB_BYPASS_EN defined, an empty buffer hands push_entry0 straight to the
// pop port and stores only the remainder; otherwise pops come from storage only.
// The caller guarantees room (push only while count <= DEPTH-2).

module wb_fifo
    import writeback_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = WbDepthDefault,
    parameter int unsigned ENTRY_W = EntryWDefault,
    localparam int unsigned PtrW   = $clog2(DEPTH),
    localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         push_cnt,
    input  logic [ENTRY_W-1:0] push_entry0,
    input  logic [ENTRY_W-1:0] push_entry1,
    input  logic               pop_req,
    output logic               pop_valid,
    output logic [ENTRY_W-1:0] pop_entry,
    output logic [CntW-1:0]    count,
    output logic [CntW-1:0]    count_next
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    count_q, count_d;

    pop_src_e           pop_src;
    logic [1:0]         n_store;
    logic [ENTRY_W-1:0] store0, store1;
    logic               pop_head;

    always_comb begin
        pop_src   = PopNone;
        pop_entry = mem_q[rd_ptr_q];
        store0    = push_entry0;
        store1    = push_entry1;
        n_store   = push_cnt;

        if (pop_req && (count_q != '0)) begin
            pop_src = PopHead;
`ifdef WB_BYPASS_EN
        end else if (pop_req && (push_cnt != 2'd0)) begin
            // Empty buffer: the older incoming entry bypasses storage.
            pop_src   = PopLane;
            pop_entry = push_entry0;
            store0    = push_entry1;
            n_store   = push_cnt - 2'd1;
`endif
        end

        pop_valid = (pop_src != PopNone);
        pop_head  = (pop_src == PopHead);

        rd_ptr_d = pop_head ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        // Pointer arithmetic wraps modulo DEPTH (power of two).
        wr_ptr_d = wr_ptr_q + PtrW'(n_store);
        count_d  = count_q + CntW'(n_store) - (pop_head ? CntW'(1) : CntW'(0));
    end

    always_ff @(posedge clk) begin
        if (n_store != 2'd0) begin
            mem_q[wr_ptr_q] <= store0;
        end
        if (n_store == 2'd2) begin
            mem_q[wr_ptr_q + PtrW'(1)] <= store1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: collects results from two execution lanes, selects ALU or
// load data per lane, and serialises them in program order onto the register
// file's single write port (decoder stage ds_i_reg_write/ds_i_addr_rd/ds_i_data_rd).
//
// Ports:
//   wb_i_clk   clock
//   wb_i_rst   synchronous active-high reset
//   wb         writeback_stage_if.slave (lane inputs, write port, ready/pending/count)
//
// Optional feature macro: WB_BYPASS_EN (see wb_fifo) gives 1-cycle latency from
// acceptance to write; without it latency is 2. The ready threshold is the same.

module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned WB_DEPTH = WbDepthDefault,
    parameter int unsigned DWIDTH   = DWidthDefault,
    parameter int unsigned AWIDTH   = AWidthDefault
) (
    input logic              wb_i_clk,
    input logic              wb_i_rst,
    writeback_stage_if.slave wb
);

    localparam int unsigned EntryW = AWIDTH + DWIDTH;
    localparam int unsigned CntW   = $clog2(WB_DEPTH + 1);

    logic              qual0, qual1;
    logic              ready, accept;
    logic [EntryW-1:0] entry0, entry1;
    logic [EntryW-1:0] first_entry, second_entry;
    logic [1:0]        push_cnt;

    logic              pop_valid;
    logic [EntryW-1:0] pop_entry;
    logic [CntW-1:0]   count;
    logic [CntW-1:0]   count_next;

    logic              reg_write_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic              pending_q;

    assign qual0 = lane_qualifies(wb.wb_i_valid0, wb.wb_i_reg_write0, |wb.wb_i_addr_rd0);
    assign qual1 = lane_qualifies(wb.wb_i_valid1, wb.wb_i_reg_write1, |wb.wb_i_addr_rd1);

    // Data selection happens at acceptance; the buffer stores the final value.
    assign entry0 = {wb.wb_i_addr_rd0,
                     wb.wb_i_memtoreg0 ? wb.wb_i_mem_data0 : wb.wb_i_alu_result0};
    assign entry1 = {wb.wb_i_addr_rd1,
                     wb.wb_i_memtoreg1 ? wb.wb_i_mem_data1 : wb.wb_i_alu_result1};

    // Room for two entries is required so both lanes can always be taken.
    assign ready  = wb.wb_i_ce & (count <= CntW'(WB_DEPTH - 2));
    assign accept = wb.wb_i_ce & ready;

    // Compact qualified lanes so the older surviving entry is always pushed first.
    always_comb begin
        push_cnt     = 2'd0;
        first_entry  = entry0;
        second_entry = entry1;
        if (accept) begin
            case ({qual1, qual0})
                2'b01:   push_cnt = 2'd1;
                2'b10: begin
                    push_cnt    = 2'd1;
                    first_entry = entry1;
                end
                2'b11:   push_cnt = 2'd2;
                default: push_cnt = 2'd0;
            endcase
        end
    end

    wb_fifo #(
        .DEPTH   (WB_DEPTH),
        .ENTRY_W (EntryW)
    ) u_fifo (
        .clk         (wb_i_clk),
        .rst         (wb_i_rst),
        .push_cnt    (push_cnt),
        .push_entry0 (first_entry),
        .push_entry1 (second_entry),
        .pop_req     (wb.wb_i_ce),
        .pop_valid   (pop_valid),
        .pop_entry   (pop_entry),
        .count       (count),
        .count_next  (count_next)
    );

    // Output register: address/data hold when nothing is popped.
    always_ff @(posedge wb_i_clk) begin
        if (wb_i_rst) begin
            reg_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            reg_write_q <= pop_valid;
            if (pop_valid) begin
                {addr_q, data_q} <= pop_entry;
            end
            pending_q <= (count_next != '0);
        end
    end

    assign wb.wb_o_ready     = ready;
    assign wb.wb_o_reg_write = reg_write_q;
    assign wb.wb_o_addr_rd   = addr_q;
    assign wb.wb_o_data_rd   = data_q;
    assign wb.wb_o_pending   = pending_q;
    assign wb.wb_o_count     = count;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for writeback_stage.
// Works with or without WB_BYPASS_EN; expected latency and occupancy follow the macro.

module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int unsigned Depth = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_stage_if #(.WB_DEPTH(Depth), .DWIDTH(DW), .AWIDTH(AW)) bus ();

    writeback_stage #(
        .WB_DEPTH (Depth),
        .DWIDTH   (DW),
        .AWIDTH   (AW)
    ) dut (
        .wb_i_clk (clk),
        .wb_i_rst (rst),
        .wb       (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic [31:0] cyc = 0;
    wr_t         wr_q[$];
    exp_t        exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every register-file write, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.wb_o_reg_write === 1'b1) begin
            wr_q.push_back('{cyc, bus.wb_o_addr_rd, bus.wb_o_data_rd});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Occupancy after one cycle with ce high and n_push entries accepted.
    function automatic int model_next(input int c, input int n_push);
`ifdef WB_BYPASS_EN
        return c + n_push - (((c > 0) || (n_push > 0)) ? 1 : 0);
`else
        return c + n_push - ((c > 0) ? 1 : 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_lanes();
        bus.wb_i_valid0      = 1'b0;
        bus.wb_i_valid1      = 1'b0;
        bus.wb_i_reg_write0  = 1'b0;
        bus.wb_i_reg_write1  = 1'b0;
        bus.wb_i_memtoreg0   = 1'b0;
        bus.wb_i_memtoreg1   = 1'b0;
        bus.wb_i_addr_rd0    = '0;
        bus.wb_i_addr_rd1    = '0;
        bus.wb_i_alu_result0 = '0;
        bus.wb_i_alu_result1 = '0;
        bus.wb_i_mem_data0   = '0;
        bus.wb_i_mem_data1   = '0;
    endtask

    task automatic set_lane0(input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                             input logic [DW-1:0] mem, input logic m2r);
        bus.wb_i_valid0      = 1'b1;
        bus.wb_i_reg_write0  = 1'b1;
        bus.wb_i_addr_rd0    = rd;
        bus.wb_i_alu_result0 = alu;
        bus.wb_i_mem_data0   = mem;
        bus.wb_i_memtoreg0   = m2r;
    endtask

    task automatic set_lane1(input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                             input logic [DW-1:0] mem, input logic m2r);
        bus.wb_i_valid1      = 1'b1;
        bus.wb_i_reg_write1  = 1'b1;
        bus.wb_i_addr_rd1    = rd;
        bus.wb_i_alu_result1 = alu;
        bus.wb_i_mem_data1   = mem;
        bus.wb_i_memtoreg1   = m2r;
    endtask

    // Push pairs until the buffer holds three entries; records what was pushed.
    task automatic fill_to_three(input int base_addr, input logic [DW-1:0] base_data);
        int mc = 0;
        int n  = 0;
        int guard = 0;
        while (mc < 3 && guard < 20) begin
            set_lane0(AW'(base_addr + n), base_data + DW'(n), ~(base_data + DW'(n)), 1'b0);
            set_lane1(AW'(base_addr + n + 1), ~(base_data + DW'(n + 1)),
                      base_data + DW'(n + 1), 1'b1);
            exp_q.push_back('{AW'(base_addr + n), base_data + DW'(n)});
            exp_q.push_back('{AW'(base_addr + n + 1), base_data + DW'(n + 1)});
            n += 2;
            tick();
            guard++;
            mc = model_next(mc, 2);
        end
        idle_lanes();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wb_i_ce = 1'b1;
        idle_lanes();
        tick();
        tick();
        checks++;
        if (bus.wb_o_reg_write !== 1'b0) begin
            failures++; $display("FAIL reset_reg_write: got %0b expected 0", bus.wb_o_reg_write);
        end
        checks++;
        if (bus.wb_o_addr_rd !== '0) begin
            failures++; $display("FAIL reset_addr: got %0h expected 0", bus.wb_o_addr_rd);
        end
        checks++;
        if (bus.wb_o_data_rd !== '0) begin
            failures++; $display("FAIL reset_data: got %0h expected 0", bus.wb_o_data_rd);
        end
        checks++;
        if (bus.wb_o_pending !== 1'b0) begin
            failures++; $display("FAIL reset_pending: got %0b expected 0", bus.wb_o_pending);
        end
        checks++;
        if (bus.wb_o_count !== CntW'(0)) begin
            failures++; $display("FAIL reset_count: got %0d expected 0", bus.wb_o_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.wb_o_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %0b expected 1", bus.wb_o_ready);
        end
    endtask

    task automatic test_single();
        set_lane0(5'd8, 32'h1234, 32'hDEAD_BEEF, 1'b0);
        tick();
        idle_lanes();
`ifndef WB_BYPASS_EN
        checks++;
        if (bus.wb_o_reg_write !== 1'b0) begin
            failures++; $display("FAIL single_early: got %0b expected 0", bus.wb_o_reg_write);
        end
        checks++;
        if (bus.wb_o_count !== CntW'(1)) begin
            failures++; $display("FAIL single_count: got %0d expected 1", bus.wb_o_count);
        end
        tick();
`endif
        checks++;
        if (bus.wb_o_reg_write !== 1'b1) begin
            failures++; $display("FAIL single_we: got %0b expected 1", bus.wb_o_reg_write);
        end
        checks++;
        if (bus.wb_o_addr_rd !== 5'd8) begin
            failures++; $display("FAIL single_addr: got %0d expected 8", bus.wb_o_addr_rd);
        end
        checks++;
        if (bus.wb_o_data_rd !== 32'h1234) begin
            failures++; $display("FAIL single_data: got %0h expected 1234", bus.wb_o_data_rd);
        end
        tick();
        checks++;
        if (bus.wb_o_reg_write !== 1'b0) begin
            failures++; $display("FAIL single_we_after: got %0b expected 0", bus.wb_o_reg_write);
        end
        checks++;
        if (bus.wb_o_pending !== 1'b0) begin
            failures++; $display("FAIL single_pending: got %0b expected 0", bus.wb_o_pending);
        end
        checks++;
        if (bus.wb_o_addr_rd !== 5'd8) begin
            failures++; $display("FAIL single_addr_hold: got %0d expected 8", bus.wb_o_addr_rd);
        end
    endtask

    task automatic test_dual_same_rd();
        wr_q.delete();
        set_lane0(5'd3, 32'h1111, 32'hAAAA, 1'b1);
        set_lane1(5'd3, 32'h5555, 32'h2222, 1'b0);
        tick();
        idle_lanes();
        repeat (4) tick();
        checks++;
        if (wr_q.size() != 2) begin
            failures++; $display("FAIL dual_count: got %0d writes expected 2", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0].addr !== 5'd3 || wr_q[0].data !== 32'hAAAA) begin
                failures++;
                $display("FAIL dual_first: got (%0d,%0h) expected (3,aaaa)",
                         wr_q[0].addr, wr_q[0].data);
            end
            checks++;
            if (wr_q[1].addr !== 5'd3 || wr_q[1].data !== 32'h5555) begin
                failures++;
                $display("FAIL dual_second: got (%0d,%0h) expected (3,5555)",
                         wr_q[1].addr, wr_q[1].data);
            end
            checks++;
            if (wr_q[1].cyc !== wr_q[0].cyc + 1) begin
                failures++;
                $display("FAIL dual_consecutive: got gap %0d expected 1",
                         wr_q[1].cyc - wr_q[0].cyc);
            end
        end
    endtask

    task automatic test_rd_zero();
        int max_cnt;
        wr_q.delete();
        set_lane0(5'd0, 32'h77, 32'h66, 1'b0);
        set_lane1(5'd9, 32'h9999, 32'h1, 1'b0);
        tick();
        idle_lanes();
        max_cnt = int'(bus.wb_o_count);
        repeat (4) begin
            tick();
            if (int'(bus.wb_o_count) > max_cnt) max_cnt = int'(bus.wb_o_count);
        end
        checks++;
        if (max_cnt > 1) begin
            failures++; $display("FAIL rd0_max_count: got %0d expected <=1", max_cnt);
        end
        checks++;
        if (wr_q.size() != 1) begin
            failures++; $display("FAIL rd0_writes: got %0d expected 1", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0].addr !== 5'd9 || wr_q[0].data !== 32'h9999) begin
                failures++;
                $display("FAIL rd0_entry: got (%0d,%0h) expected (9,9999)",
                         wr_q[0].addr, wr_q[0].data);
            end
        end
    endtask

    // Compare recorded writes against the expected queue, entry by entry.
    task automatic compare_order(input string tag);
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_size: got %0d expected %0d", tag, wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
                failures++;
                $display("FAIL %s_entry%0d: got (%0d,%0h) expected (%0d,%0h)", tag, i,
                         wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   mc = 0;
        int   k  = 0;
        int   budget = 0;
        int   n_push;
        logic exp_rdy;
        bit   saw_not_ready = 0;
        wr_q.delete();
        exp_q.delete();
        while (k < 12 && budget < 40) begin
            exp_rdy = (mc <= int'(Depth) - 2);
            checks++;
            if (bus.wb_o_ready !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_ready: got %0b expected %0b (cycle %0d)",
                         bus.wb_o_ready, exp_rdy, budget);
            end
            checks++;
            if (bus.wb_o_count !== CntW'(mc)) begin
                failures++;
                $display("FAIL b2b_count: got %0d expected %0d", bus.wb_o_count, mc);
            end
            if (exp_rdy) begin
                set_lane0(AW'(k + 1), ~(32'hB000 + DW'(k)), 32'hB000 + DW'(k), 1'b1);
                set_lane1(AW'(k + 2), 32'hB000 + DW'(k + 1), 32'h0, 1'b0);
                exp_q.push_back('{AW'(k + 1), 32'hB000 + DW'(k)});
                exp_q.push_back('{AW'(k + 2), 32'hB000 + DW'(k + 1)});
                k += 2;
                n_push = 2;
            end else begin
                // Lanes presented while not ready must be ignored.
                set_lane0(5'd31, 32'hBAD0, 32'hBAD1, 1'b0);
                set_lane1(5'd30, 32'hBAD2, 32'hBAD3, 1'b0);
                saw_not_ready = 1;
                n_push = 0;
            end
            tick();
            mc = model_next(mc, n_push);
            budget++;
        end
        idle_lanes();
        checks++;
        if (saw_not_ready != 1'b1) begin
            failures++; $display("FAIL b2b_ready_drop: got no drop expected ready low once");
        end
        budget = 0;
        while (wr_q.size() < 12 && budget < 30) begin
            tick();
            budget++;
        end
        tick();
        checks++;
        if (bus.wb_o_pending !== 1'b0) begin
            failures++; $display("FAIL b2b_pending: got %0b expected 0", bus.wb_o_pending);
        end
        compare_order("b2b");
    endtask

    task automatic test_stall();
        int budget = 0;
        wr_q.delete();
        exp_q.delete();
        fill_to_three(16, 32'hC000);
        bus.wb_i_ce = 1'b0;
        repeat (4) begin
            tick();
            checks++;
            if (bus.wb_o_reg_write !== 1'b0) begin
                failures++; $display("FAIL stall_we: got %0b expected 0", bus.wb_o_reg_write);
            end
            checks++;
            if (bus.wb_o_count !== CntW'(3)) begin
                failures++; $display("FAIL stall_count: got %0d expected 3", bus.wb_o_count);
            end
            checks++;
            if (bus.wb_o_ready !== 1'b0) begin
                failures++; $display("FAIL stall_ready: got %0b expected 0", bus.wb_o_ready);
            end
        end
        bus.wb_i_ce = 1'b1;
        while (wr_q.size() < exp_q.size() && budget < 30) begin
            tick();
            budget++;
        end
        repeat (2) tick();
        compare_order("stall");
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        fill_to_three(24, 32'hD000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_q.delete();
        checks++;
        if (bus.wb_o_count !== CntW'(0)) begin
            failures++; $display("FAIL rstmid_count: got %0d expected 0", bus.wb_o_count);
        end
        checks++;
        if (bus.wb_o_pending !== 1'b0) begin
            failures++; $display("FAIL rstmid_pending: got %0b expected 0", bus.wb_o_pending);
        end
        repeat (5) begin
            checks++;
            if (bus.wb_o_reg_write !== 1'b0) begin
                failures++; $display("FAIL rstmid_we: got %0b expected 0", bus.wb_o_reg_write);
            end
            tick();
        end
        checks++;
        if (wr_q.size() != 0) begin
            failures++; $display("FAIL rstmid_stale: got %0d writes expected 0", wr_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.wb_i_ce = 1'b0;
        idle_lanes();
        test_reset();
        test_single();
        test_dual_same_rd();
        test_rd_zero();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
